// File: rtl/conv_stream_master.sv
// conv_stream_master: host-loaded stream driver for the 8x4 convolution core.
// The host fills the X/F stores while the block is idle, then pulses start. The
// block streams X and F on independent valid/ready channels, collects Y_CNT results
// into a buffer that can be read at any time, and pulses done once at the end.
module conv_stream_master #(
    parameter  int DATA_WIDTH_X = 8,
    parameter  int DATA_WIDTH_F = 8,
    parameter  int X_SIZE       = 8,
    parameter  int F_SIZE       = 4,
    localparam int Y_CNT        = X_SIZE - F_SIZE + 1,
    localparam int Y_W          = DATA_WIDTH_X + DATA_WIDTH_F + 2,
    localparam int AW           = $clog2(X_SIZE),
    localparam int FAW          = $clog2(F_SIZE),
    localparam int RAW          = $clog2(Y_CNT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DATA_WIDTH_X-1:0] wr_data,
    input  logic                    start,
    input  logic                    hold_y,
    output logic                    busy,
    output logic                    done,
    output logic                    m_valid_x,
    output logic [DATA_WIDTH_X-1:0] m_data_x,
    input  logic                    m_ready_x,
    output logic                    m_valid_f,
    output logic [DATA_WIDTH_F-1:0] m_data_f,
    input  logic                    m_ready_f,
    input  logic                    s_valid_y,
    input  logic [Y_W-1:0]          s_data_y,
    output logic                    s_ready_y,
    input  logic [RAW-1:0]          rd_addr,
    output logic [Y_W-1:0]          rd_data
);

    // Counters need one extra code so they can reach the full transfer count.
    localparam int XCW = $clog2(X_SIZE + 1);
    localparam int FCW = $clog2(F_SIZE + 1);
    localparam int YCW = $clog2(Y_CNT + 1);
    localparam logic [XCW-1:0] X_END = XCW'(X_SIZE);
    localparam logic [FCW-1:0] F_END = FCW'(F_SIZE);
    localparam logic [YCW-1:0] Y_END = YCW'(Y_CNT);
    localparam logic [RAW-1:0] RD_END = RAW'(Y_CNT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t state, state_next;

    logic [XCW-1:0] x_cnt;
    logic [FCW-1:0] f_cnt;
    logic [YCW-1:0] y_cnt;

    logic [DATA_WIDTH_X-1:0] x_mem   [X_SIZE];
    logic [DATA_WIDTH_F-1:0] f_mem   [F_SIZE];
    logic [Y_W-1:0]          res_mem [Y_CNT];

    logic x_done, f_done, y_done;
    logic hs_x, hs_f, hs_y;
    logic idle_start;

    assign x_done     = (x_cnt == X_END);
    assign f_done     = (f_cnt == F_END);
    assign y_done     = (y_cnt == Y_END);
    assign hs_x       = m_valid_x && m_ready_x;
    assign hs_f       = m_valid_f && m_ready_f;
    assign hs_y       = s_valid_y && s_ready_y;
    assign idle_start = (state == S_IDLE) && start;

    // State register; reset aborts any transaction in flight without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave RUN only once every channel has finished its quota.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (x_done && f_done && y_done) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state and channel progress.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        m_valid_x = 1'b0;
        m_valid_f = 1'b0;
        s_ready_y = 1'b0;
        case (state)
            S_RUN: begin
                busy      = 1'b1;
                m_valid_x = !x_done;
                m_valid_f = !f_done;
                s_ready_y = !y_done && !hold_y;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    // Beat counters: cleared on the accepting start edge, advanced per handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt <= '0;
            f_cnt <= '0;
            y_cnt <= '0;
        end else if (idle_start) begin
            x_cnt <= '0;
            f_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (hs_x) x_cnt <= x_cnt + XCW'(1);
            if (hs_f) f_cnt <= f_cnt + FCW'(1);
            if (hs_y) y_cnt <= y_cnt + YCW'(1);
        end
    end

    // Host writes into the vector stores are only honoured while idle.
    always_ff @(posedge clk) begin
        if (wr_en && (state == S_IDLE)) begin
            if (!wr_sel) begin
                x_mem[wr_addr] <= wr_data;
            end else begin
                f_mem[wr_addr[FAW-1:0]] <= wr_data[DATA_WIDTH_F-1:0];
            end
        end
    end

    // Capture each accepted Y beat at the current result index.
    always_ff @(posedge clk) begin
        if (hs_y) begin
            res_mem[y_cnt[RAW-1:0]] <= s_data_y;
        end
    end

    // Channel data follows the counters, so it holds steady until the handshake.
    assign m_data_x = x_mem[x_cnt[AW-1:0]];
    assign m_data_f = f_mem[f_cnt[FAW-1:0]];
    assign rd_data  = (rd_addr < RD_END) ? res_mem[rd_addr] : '0;

endmodule

// File: tb/tb_conv_stream_master.sv
// Testbench for conv_stream_master: the bench plays both host and convolution core.
// Y beats returned by the core stand-in are computed from the X/F beats it actually
// received; expected results are derived directly from the loaded vectors.
module tb_conv_stream_master;

    localparam int DX = 8;
    localparam int DF = 8;
    localparam int XS = 8;
    localparam int FS = 4;
    localparam int YC = XS - FS + 1;
    localparam int YW = DX + DF + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [DX-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          hold_y = 1'b0;
    logic          busy, done;
    logic          m_valid_x, m_valid_f, s_ready_y;
    logic [DX-1:0] m_data_x;
    logic [DF-1:0] m_data_f;
    logic          m_ready_x = 1'b0;
    logic          m_ready_f = 1'b0;
    logic          s_valid_y = 1'b0;
    logic [YW-1:0] s_data_y = '0;
    logic [2:0]    rd_addr = '0;
    logic [YW-1:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    int x_ref [XS];
    int f_ref [FS];

    conv_stream_master dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .hold_y(hold_y), .busy(busy), .done(done),
        .m_valid_x(m_valid_x), .m_data_x(m_data_x), .m_ready_x(m_ready_x),
        .m_valid_f(m_valid_f), .m_data_f(m_data_f), .m_ready_f(m_ready_f),
        .s_valid_y(s_valid_y), .s_data_y(s_data_y), .s_ready_y(s_ready_y),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write the X and F stores through the host port (values also kept in the reference).
    task automatic load(input int xs [XS], input int fs [FS]);
        for (int i = 0; i < XS; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'(i); wr_data = DX'(xs[i]);
            x_ref[i] = xs[i];
        end
        for (int i = 0; i < FS; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'(i); wr_data = DX'(fs[i]);
            f_ref[i] = fs[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Expected result word k straight from the loaded vectors.
    function automatic logic [YW-1:0] ref_y(input int k);
        int s = 0;
        for (int j = 0; j < FS; j++) s += x_ref[k + j] * f_ref[j];
        return YW'(s);
    endfunction

    // One transaction. xmode: 0 always ready, 1 toggle, 2 random.
    // hold_cyc: cycles of hold_y after start. inject: start/wr_en pulse during RUN.
    // abort_at: assert reset once that many X beats have been taken (-1 = never).
    task automatic run_txn(input string name, input int xmode, input int hold_cyc,
                           input bit inject, input int abort_at);
        int rx_x [$];
        int rx_f [$];
        int ny = 0, ndone = 0, x_last = -1;
        bit stall_x = 0, stall_f = 0, fin = 0, aborted = 0;
        logic [DX-1:0] last_x = '0;
        logic [DF-1:0] last_f = '0;
        int ysum;

        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 400 && !fin && !aborted; cyc++) begin
            @(negedge clk);
            start   = (inject && cyc == 2);
            wr_en   = (inject && cyc == 2);
            wr_sel  = 1'b0; wr_addr = 3'd0; wr_data = 8'h5A;
            hold_y  = (cyc < hold_cyc);
            case (xmode)
                0:       m_ready_x = 1'b1;
                1:       m_ready_x = (cyc % 2 == 0);
                default: m_ready_x = ($urandom_range(0, 2) != 0);
            endcase
            m_ready_f = (xmode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (rx_x.size() == XS && rx_f.size() == FS && ny < YC &&
                (xmode == 0 || $urandom_range(0, 3) != 0)) begin
                ysum = 0;
                for (int j = 0; j < FS; j++) ysum += rx_x[ny + j] * rx_f[j];
                s_valid_y = 1'b1;
                s_data_y  = YW'(ysum);
            end else begin
                s_valid_y = 1'b0;
                s_data_y  = YW'($urandom);
            end
            #1;
            if (cyc == 0) begin
                check({name, " busy_after_start"}, 32'(busy), 32'd1);
                check({name, " valid_x_after_start"}, 32'(m_valid_x), 32'd1);
            end
            if (stall_x) begin
                check({name, " x_hold_valid"}, 32'(m_valid_x), 32'd1);
                check({name, " x_hold_data"}, 32'(m_data_x), 32'(last_x));
            end
            if (stall_f) check({name, " f_hold_data"}, 32'(m_data_f), 32'(last_f));
            if (hold_y) check({name, " ready_y_held"}, 32'(s_ready_y), 32'd0);
            if (m_valid_x && m_ready_x) begin
                rx_x.push_back(int'($signed(m_data_x)));
                x_last = cyc;
            end
            if (m_valid_f && m_ready_f) rx_f.push_back(int'($signed(m_data_f)));
            if (s_valid_y && s_ready_y) ny++;
            stall_x = m_valid_x && !m_ready_x; last_x = m_data_x;
            stall_f = m_valid_f && !m_ready_f; last_f = m_data_f;
            if (done) begin
                ndone++;
                fin = 1;
            end
            if (abort_at >= 0 && rx_x.size() == abort_at) begin
                @(negedge clk);
                reset = 1'b0;
                #1;
                check({name, " abort_valid_x"}, 32'(m_valid_x), 32'd0);
                check({name, " abort_valid_f"}, 32'(m_valid_f), 32'd0);
                check({name, " abort_ready_y"}, 32'(s_ready_y), 32'd0);
                check({name, " abort_busy"}, 32'(busy), 32'd0);
                check({name, " abort_done"}, 32'(done), 32'd0);
                @(negedge clk);
                reset = 1'b1;
                aborted = 1;
            end
        end
        start = 1'b0; wr_en = 1'b0; hold_y = 1'b0; s_valid_y = 1'b0;
        m_ready_x = 1'b0; m_ready_f = 1'b0;
        @(negedge clk);
        #1;
        check({name, " idle_busy"}, 32'(busy), 32'd0);
        check({name, " idle_done"}, 32'(done), 32'd0);
        if (aborted) begin
            $display("txn %s: aborted after %0d X beats", name, rx_x.size());
            return;
        end
        check({name, " x_beats"}, 32'(rx_x.size()), 32'(XS));
        check({name, " f_beats"}, 32'(rx_f.size()), 32'(FS));
        check({name, " y_beats"}, 32'(ny), 32'(YC));
        check({name, " done_pulses"}, 32'(ndone), 32'd1);
        if (xmode == 0) check({name, " x_last_cycle"}, 32'(x_last), 32'(XS - 1));
        for (int i = 0; i < XS && i < rx_x.size(); i++)
            check({name, " x_data"}, 32'(rx_x[i]), 32'(x_ref[i]));
        for (int i = 0; i < FS && i < rx_f.size(); i++)
            check({name, " f_data"}, 32'(rx_f[i]), 32'(f_ref[i]));
        for (int k = 0; k < YC; k++) begin
            rd_addr = 3'(k);
            #1;
            check({name, " result"}, 32'(rd_data), 32'(ref_y(k)));
        end
        $display("txn %s: x=%0d f=%0d y=%0d done=%0d r0=%0d", name,
                 rx_x.size(), rx_f.size(), ny, ndone, $signed(ref_y(0)));
    endtask

    initial begin
        int xs [XS];
        int fs [FS];

        // Reset state
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset valid_x", 32'(m_valid_x), 32'd0);
        check("reset valid_f", 32'(m_valid_f), 32'd0);
        check("reset ready_y", 32'(s_ready_y), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // T1: ramp X, unit F, always ready
        for (int i = 0; i < XS; i++) xs[i] = i + 1;
        for (int i = 0; i < FS; i++) fs[i] = 1;
        load(xs, fs);
        run_txn("T1", 0, 0, 0, -1);

        // T2: same data, X ready toggling
        run_txn("T2", 1, 0, 0, -1);

        // T3: extreme negative inputs
        for (int i = 0; i < XS; i++) xs[i] = -128;
        for (int i = 0; i < FS; i++) fs[i] = -128;
        load(xs, fs);
        run_txn("T3", 0, 0, 0, -1);

        // Random data, random handshakes
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < XS; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
            for (int i = 0; i < FS; i++) fs[i] = int'($urandom_range(0, 255)) - 128;
            load(xs, fs);
            run_txn("RND", 2, 0, 0, -1);
        end

        // T4: Y backpressure for 20 cycles
        run_txn("T4", 2, 20, 0, -1);

        // T5: start and write pulsed during RUN; T6 restart re-checks the store
        run_txn("T5", 0, 0, 1, -1);

        // T6: reset after 3 X beats, then full transaction from index 0
        run_txn("T6a", 0, 0, 0, 3);
        run_txn("T6b", 0, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
